// File: rtl/if_stage.sv
// Instruction fetch stage: single-outstanding fetch FSM feeding a 2-entry instruction FIFO,
// with delay-slot aware redirects. Define IF_PERF_CNT_EN to add fetch/bubble counters.
package if_stage_pkg;

  typedef enum logic {
    RST_DISABLE = 1'b0,
    RST_ENABLE  = 1'b1
  } reset_status_t;

  typedef struct packed {
    logic        en;
    logic [31:0] addr;
  } jump_t;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
  } inst_t;

endpackage

module if_stage
  import if_stage_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic          clk,
  input  reset_status_t rst,
  input  logic          stall,
  input  jump_t         id_jumpreq,
  output logic          imem_req,
  output logic [31:0]   imem_addr,
  input  logic          imem_ack,
  input  logic [31:0]   imem_data,
  output inst_t         if_inst_o,
  output logic          if_valid_o
`ifdef IF_PERF_CNT_EN
  ,
  output logic [31:0]   if_perf_fetch_o,
  output logic [31:0]   if_perf_bubble_o
`endif
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_REQ   = 2'd1,
    ST_FLUSH = 2'd2
  } fetch_state_t;

  fetch_state_t state_r, state_n;
  logic [31:0]  pc_r, pc_n;
  logic [31:0]  addr_r, addr_n;
  logic         req_r;
  inst_t        fifo0_r, fifo0_n;
  inst_t        fifo1_r, fifo1_n;
  logic [1:0]   count_r, cnt_n;
  logic         valid_r;
  logic         ds_flag_r, ds_flag_n;
  logic         ds_pend_r, ds_pend_n;
  logic         redir_pend_r, redir_n;
  logic [31:0]  tgt_r, tgt_n;

  logic         pop_s;
  logic         accept_s;
  logic         ack_s;
  logic         busy_s;
  logic         keep_head_s;
  logic         wr_s;
  logic [31:0]  jump_tgt_s;
  inst_t        new_s;
  logic         unused_s;

  // Target low bits carry no meaning for word-aligned fetch.
  assign unused_s   = ^id_jumpreq.addr[1:0];
  assign jump_tgt_s = {id_jumpreq.addr[31:2], 2'b00};

  // Handshake qualifiers and redirect classification.
  always_comb begin
    pop_s       = valid_r & ~stall;
    accept_s    = id_jumpreq.en & ~stall & ~ds_flag_r & ~ds_pend_r;
    ack_s       = imem_ack & (state_r != ST_IDLE);
    // Head present at redirect: it is the delay slot and leaves this cycle.
    keep_head_s = accept_s & valid_r;
    wr_s        = ack_s & (state_r == ST_REQ) & ~keep_head_s;
    new_s       = {addr_r, imem_data};
    case (state_r)
      ST_IDLE:  busy_s = 1'b0;
      ST_REQ:   busy_s = ~imem_ack;
      ST_FLUSH: busy_s = ~imem_ack;
      default:  busy_s = 1'b0;
    endcase
  end

  // FIFO next state: pop shifts entry 1 forward, writes land behind the survivors.
  always_comb begin
    fifo0_n = fifo0_r;
    fifo1_n = fifo1_r;
    cnt_n   = count_r;
    if (keep_head_s) begin
      fifo0_n = '0;
      fifo1_n = '0;
      cnt_n   = 2'd0;
    end else begin
      if (pop_s) begin
        fifo0_n = fifo1_r;
        fifo1_n = '0;
        cnt_n   = count_r - 2'd1;
      end else begin
        cnt_n   = count_r;
      end
      if (wr_s) begin
        if (cnt_n == 2'd0) begin
          fifo0_n = new_s;
        end else begin
          fifo1_n = new_s;
        end
        cnt_n = cnt_n + 2'd1;
      end else begin
        cnt_n = cnt_n;
      end
    end
  end

  // Delay-slot tracking: ds_pend = redirect taken but delay slot not yet handed to decode.
  always_comb begin
    if (pop_s) begin
      ds_flag_n = keep_head_s | ds_pend_r;
      ds_pend_n = 1'b0;
    end else if (accept_s) begin
      ds_flag_n = ds_flag_r;
      ds_pend_n = 1'b1;
    end else begin
      ds_flag_n = ds_flag_r;
      ds_pend_n = ds_pend_r;
    end
  end

  // Fetch address sequencing and FSM next state.
  always_comb begin
    pc_n    = pc_r;
    tgt_n   = tgt_r;
    redir_n = redir_pend_r;
    addr_n  = addr_r;
    state_n = state_r;
    if (keep_head_s) begin
      pc_n    = jump_tgt_s;
      redir_n = 1'b0;
    end else if (wr_s) begin
      // The word just written is the delay slot when a redirect is pending.
      if (accept_s) begin
        pc_n = jump_tgt_s;
      end else if (redir_pend_r) begin
        pc_n    = tgt_r;
        redir_n = 1'b0;
      end else begin
        pc_n = pc_r + 32'd4;
      end
    end else if (accept_s) begin
      redir_n = 1'b1;
      tgt_n   = jump_tgt_s;
    end else begin
      pc_n = pc_r;
    end

    if (busy_s) begin
      if (keep_head_s || (state_r == ST_FLUSH)) begin
        state_n = ST_FLUSH;
      end else begin
        state_n = ST_REQ;
      end
    end else if (cnt_n == 2'd2) begin
      state_n = ST_IDLE;
    end else begin
      state_n = ST_REQ;
      addr_n  = pc_n;
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst == RST_ENABLE) begin
      state_r      <= ST_IDLE;
      pc_r         <= RESET_PC;
      addr_r       <= 32'h0000_0000;
      req_r        <= 1'b0;
      fifo0_r      <= '0;
      fifo1_r      <= '0;
      count_r      <= 2'd0;
      valid_r      <= 1'b0;
      ds_flag_r    <= 1'b0;
      ds_pend_r    <= 1'b0;
      redir_pend_r <= 1'b0;
      tgt_r        <= 32'h0000_0000;
    end else begin
      state_r      <= state_n;
      pc_r         <= pc_n;
      addr_r       <= addr_n;
      req_r        <= (state_n != ST_IDLE);
      fifo0_r      <= fifo0_n;
      fifo1_r      <= fifo1_n;
      count_r      <= cnt_n;
      valid_r      <= (cnt_n != 2'd0);
      ds_flag_r    <= ds_flag_n;
      ds_pend_r    <= ds_pend_n;
      redir_pend_r <= redir_n;
      tgt_r        <= tgt_n;
    end
  end

  assign imem_req   = req_r;
  assign imem_addr  = addr_r;
  assign if_inst_o  = fifo0_r;
  assign if_valid_o = valid_r;

`ifdef IF_PERF_CNT_EN
  logic [31:0] perf_fetch_r;
  logic [31:0] perf_bubble_r;

  // Saturating fetch and bubble counters.
  always_ff @(posedge clk) begin
    if (rst == RST_ENABLE) begin
      perf_fetch_r  <= 32'h0000_0000;
      perf_bubble_r <= 32'h0000_0000;
    end else begin
      if (wr_s && (perf_fetch_r != 32'hFFFF_FFFF)) begin
        perf_fetch_r <= perf_fetch_r + 32'd1;
      end
      if (!stall && !valid_r && (perf_bubble_r != 32'hFFFF_FFFF)) begin
        perf_bubble_r <= perf_bubble_r + 32'd1;
      end
    end
  end

  assign if_perf_fetch_o  = perf_fetch_r;
  assign if_perf_bubble_o = perf_bubble_r;
`endif

endmodule
